trace_capture_buffer: RTL and testbench

- Consumes the 2-lane retirement trace bundle (per lane: valid, iaddr, insn, priv, exception, interrupt, cause, tval) fanned out by the trace nexus.
- Compacts valid lanes in program order into a circular buffer and drains one entry per cycle over a valid/ready port to the debug/trace-export side.
- Tracks drops on overflow.

---
 rtl/trace_pkg.sv | 42 ++++
 rtl/trace_fifo_2w1r.sv | 32 +++
 rtl/trace_capture_buffer.sv | 148 ++++++++++++++
 tb/tb_trace_capture_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared trace bundle definitions: field widths, the packed entry record
// and a helper that assembles an entry from one lane's fields.
package trace_pkg;

  localparam int TRACE_IADDR_W = 40;
  localparam int TRACE_INSN_W  = 32;
  localparam int TRACE_PRIV_W  = 3;
  localparam int TRACE_CAUSE_W = 64;
  localparam int TRACE_TVAL_W  = 40;

  // One retired instruction as stored in the capture buffer (181 bits)
  typedef struct packed {
    logic [TRACE_IADDR_W-1:0] iaddr;
    logic [TRACE_INSN_W-1:0]  insn;
    logic [TRACE_PRIV_W-1:0]  priv;
    logic                     exception;
    logic                     interrupt;
    logic [TRACE_CAUSE_W-1:0] cause;
    logic [TRACE_TVAL_W-1:0]  tval;
  } trace_entry_t;

  function automatic trace_entry_t pack_entry(
    input logic [TRACE_IADDR_W-1:0] iaddr,
    input logic [TRACE_INSN_W-1:0]  insn,
    input logic [TRACE_PRIV_W-1:0]  priv,
    input logic                     exception,
    input logic                     interrupt,
    input logic [TRACE_CAUSE_W-1:0] cause,
    input logic [TRACE_TVAL_W-1:0]  tval
  );
    trace_entry_t e;
    e.iaddr     = iaddr;
    e.insn      = insn;
    e.priv      = priv;
    e.exception = exception;
    e.interrupt = interrupt;
    e.cause     = cause;
    e.tval      = tval;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Circular entry storage with two write ports at wptr and wptr+1 and one
// combinational read port. Pointer and occupancy tracking live in the top.
module trace_fifo_2w1r
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic [AW-1:0] wptr,
  input  logic          we_0,
  input  trace_entry_t  wdata_0,
  input  logic          we_1,
  input  trace_entry_t  wdata_1,
  input  logic [AW-1:0] rptr,
  output trace_entry_t  rdata
);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr_inc;

  assign wptr_inc = wptr + AW'(1);

  // Both ports write in the same cycle; addresses differ by one so they never collide
  always_ff @(posedge clock) begin
    if (we_0) mem[wptr]     <= wdata_0;
    if (we_1) mem[wptr_inc] <= wdata_1;
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Two-lane retirement trace capture: compacts valid lanes in program order
// into a circular buffer, drains one entry per cycle, and counts drops.
module trace_capture_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     in_0_valid,
  input  logic [TRACE_IADDR_W-1:0] in_0_iaddr,
  input  logic [TRACE_INSN_W-1:0]  in_0_insn,
  input  logic [TRACE_PRIV_W-1:0]  in_0_priv,
  input  logic                     in_0_exception,
  input  logic                     in_0_interrupt,
  input  logic [TRACE_CAUSE_W-1:0] in_0_cause,
  input  logic [TRACE_TVAL_W-1:0]  in_0_tval,
  input  logic                     in_1_valid,
  input  logic [TRACE_IADDR_W-1:0] in_1_iaddr,
  input  logic [TRACE_INSN_W-1:0]  in_1_insn,
  input  logic [TRACE_PRIV_W-1:0]  in_1_priv,
  input  logic                     in_1_exception,
  input  logic                     in_1_interrupt,
  input  logic [TRACE_CAUSE_W-1:0] in_1_cause,
  input  logic [TRACE_TVAL_W-1:0]  in_1_tval,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TRACE_IADDR_W-1:0] out_iaddr,
  output logic [TRACE_INSN_W-1:0]  out_insn,
  output logic [TRACE_PRIV_W-1:0]  out_priv,
  output logic                     out_exception,
  output logic                     out_interrupt,
  output logic [TRACE_CAUSE_W-1:0] out_cause,
  output logic [TRACE_TVAL_W-1:0]  out_tval,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [AW:0]      count_reg;
  logic             overflow_reg;
  logic [CNT_W-1:0] drop_count_reg;

  logic             acc_0;
  logic             acc_1;
  logic [1:0]       req;
  logic [1:0]       n_wr;
  logic [1:0]       n_drop;
  logic [AW:0]      free;
  logic             pop;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_count_next;

  trace_entry_t lane_0_entry;
  trace_entry_t lane_1_entry;
  trace_entry_t slot_0_entry;
  trace_entry_t head_entry;

  assign acc_0 = en & in_0_valid;
  assign acc_1 = en & in_1_valid;
  assign req   = {1'b0, acc_0} + {1'b0, acc_1};

  // Free space comes from the registered count only, so a pop this cycle never makes room
  assign free = (AW+1)'(DEPTH) - count_reg;
  assign pop  = out_valid & out_ready;

  // Clamp the write count to the available space; lane 0 wins when only one slot is left
  always_comb begin
    n_wr = req;
    if (free == '0) begin
      n_wr = 2'd0;
    end else if ((free == (AW+1)'(1)) && (req == 2'd2)) begin
      n_wr = 2'd1;
    end
  end

  assign n_drop = req - n_wr;

  assign drop_sum        = {1'b0, drop_count_reg} + (CNT_W+1)'(n_drop);
  assign drop_count_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

  assign lane_0_entry = pack_entry(in_0_iaddr, in_0_insn, in_0_priv, in_0_exception,
                                   in_0_interrupt, in_0_cause, in_0_tval);
  assign lane_1_entry = pack_entry(in_1_iaddr, in_1_insn, in_1_priv, in_1_exception,
                                   in_1_interrupt, in_1_cause, in_1_tval);

  // With only lane 1 accepted it takes the first slot so no hole is left at wptr
  assign slot_0_entry = acc_0 ? lane_0_entry : lane_1_entry;

  trace_fifo_2w1r #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .wptr   (wptr_reg),
    .we_0   (~clear & (n_wr != 2'd0)),
    .wdata_0(slot_0_entry),
    .we_1   (~clear & (n_wr == 2'd2)),
    .wdata_1(lane_1_entry),
    .rptr   (rptr_reg),
    .rdata  (head_entry)
  );

  // Pointer, occupancy and drop bookkeeping; clear overrides everything else this cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (clear) begin
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      wptr_reg  <= wptr_reg + AW'(n_wr);
      rptr_reg  <= rptr_reg + AW'(pop);
      count_reg <= count_reg + (AW+1)'(n_wr) - (AW+1)'(pop);
      if (n_drop != 2'd0) begin
        overflow_reg   <= 1'b1;
        drop_count_reg <= drop_count_next;
      end
    end
  end

  assign out_valid     = (count_reg != '0);
  assign out_iaddr     = out_valid ? head_entry.iaddr     : '0;
  assign out_insn      = out_valid ? head_entry.insn      : '0;
  assign out_priv      = out_valid ? head_entry.priv      : '0;
  assign out_exception = out_valid ? head_entry.exception : 1'b0;
  assign out_interrupt = out_valid ? head_entry.interrupt : 1'b0;
  assign out_cause     = out_valid ? head_entry.cause     : '0;
  assign out_tval      = out_valid ? head_entry.tval      : '0;

  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: a table of per-cycle vectors
// with hand-computed results, a queue-model wrap-around run, and an
// asynchronous reset check.
module tb_trace_capture_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic        clear;
  logic        in_0_valid;
  logic [39:0] in_0_iaddr;
  logic [31:0] in_0_insn;
  logic [2:0]  in_0_priv;
  logic        in_0_exception;
  logic        in_0_interrupt;
  logic [63:0] in_0_cause;
  logic [39:0] in_0_tval;
  logic        in_1_valid;
  logic [39:0] in_1_iaddr;
  logic [31:0] in_1_insn;
  logic [2:0]  in_1_priv;
  logic        in_1_exception;
  logic        in_1_interrupt;
  logic [63:0] in_1_cause;
  logic [39:0] in_1_tval;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_iaddr;
  logic [31:0] out_insn;
  logic [2:0]  out_priv;
  logic        out_exception;
  logic        out_interrupt;
  logic [63:0] out_cause;
  logic [39:0] out_tval;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_count;

  trace_capture_buffer #(.DEPTH(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .en(en), .clear(clear),
    .in_0_valid(in_0_valid), .in_0_iaddr(in_0_iaddr), .in_0_insn(in_0_insn),
    .in_0_priv(in_0_priv), .in_0_exception(in_0_exception),
    .in_0_interrupt(in_0_interrupt), .in_0_cause(in_0_cause), .in_0_tval(in_0_tval),
    .in_1_valid(in_1_valid), .in_1_iaddr(in_1_iaddr), .in_1_insn(in_1_insn),
    .in_1_priv(in_1_priv), .in_1_exception(in_1_exception),
    .in_1_interrupt(in_1_interrupt), .in_1_cause(in_1_cause), .in_1_tval(in_1_tval),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_iaddr(out_iaddr), .out_insn(out_insn), .out_priv(out_priv),
    .out_exception(out_exception), .out_interrupt(out_interrupt),
    .out_cause(out_cause), .out_tval(out_tval),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        clr;
    logic        v0;
    logic        v1;
    logic [39:0] a0;
    logic [39:0] a1;
    logic        rdy;
    logic [4:0]  exp_count;
    logic        exp_valid;
    logic [39:0] exp_head;
    logic        exp_ovf;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t        vecs[$];
  logic [39:0] mq[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Secondary lane fields are derived from the address so every field carries a distinct pattern
  function automatic logic [31:0] insn_of(input logic [39:0] a);
    return 32'h13 + {16'h0, a[15:0]};
  endfunction
  function automatic logic [2:0]  priv_of(input logic [39:0] a);  return a[4:2]; endfunction
  function automatic logic        exc_of(input logic [39:0] a);   return a[2];   endfunction
  function automatic logic        int_of(input logic [39:0] a);   return a[3];   endfunction
  function automatic logic [63:0] cause_of(input logic [39:0] a); return {24'h0, a}; endfunction
  function automatic logic [39:0] tval_of(input logic [39:0] a);  return a ^ 40'hFF_FFFF_FFFF; endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic ev, input logic [39:0] eh);
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    if (ev) begin
      chk({tag, " iaddr"}, 64'(out_iaddr), 64'(eh));
      chk({tag, " insn"},  64'(out_insn),  64'(insn_of(eh)));
      chk({tag, " priv"},  64'(out_priv),  64'(priv_of(eh)));
      chk({tag, " exc"},   64'(out_exception), 64'(exc_of(eh)));
      chk({tag, " int"},   64'(out_interrupt), 64'(int_of(eh)));
      chk({tag, " cause"}, out_cause, cause_of(eh));
      chk({tag, " tval"},  64'(out_tval), 64'(tval_of(eh)));
    end else begin
      chk({tag, " gated payload"},
          64'(out_iaddr) | 64'(out_insn) | 64'(out_priv) | 64'(out_exception) |
          64'(out_interrupt) | out_cause | 64'(out_tval), 64'h0);
    end
  endtask

  task automatic add(input logic e, c, v0, v1, input logic [39:0] a0, a1, input logic rdy,
                     input logic [4:0] ec, input logic ev, input logic [39:0] eh,
                     input logic eo, input logic [15:0] ed);
    vec_t v;
    v.en = e; v.clr = c; v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1; v.rdy = rdy;
    v.exp_count = ec; v.exp_valid = ev; v.exp_head = eh; v.exp_ovf = eo; v.exp_drop = ed;
    vecs.push_back(v);
  endtask

  // Apply one cycle of stimulus, then settle just after the edge for sampling
  task automatic drive(input logic e, c, v0, v1, input logic [39:0] a0, a1, input logic rdy);
    en = e; clear = c; out_ready = rdy;
    in_0_valid = v0; in_0_iaddr = a0; in_0_insn = insn_of(a0); in_0_priv = priv_of(a0);
    in_0_exception = exc_of(a0); in_0_interrupt = int_of(a0);
    in_0_cause = cause_of(a0); in_0_tval = tval_of(a0);
    in_1_valid = v1; in_1_iaddr = a1; in_1_insn = insn_of(a1); in_1_priv = priv_of(a1);
    in_1_exception = exc_of(a1); in_1_interrupt = int_of(a1);
    in_1_cause = cause_of(a1); in_1_tval = tval_of(a1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    int   n_free;
    int   n_req;
    reset = 1'b1;
    en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    in_0_valid = 1'b0; in_0_iaddr = '0; in_0_insn = '0; in_0_priv = '0;
    in_0_exception = 1'b0; in_0_interrupt = 1'b0; in_0_cause = '0; in_0_tval = '0;
    in_1_valid = 1'b0; in_1_iaddr = '0; in_1_insn = '0; in_1_priv = '0;
    in_1_exception = 1'b0; in_1_interrupt = 1'b0; in_1_cause = '0; in_1_tval = '0;

    // Vector table: en clr v0 v1 a0 a1 rdy | count valid head ovf drops
    add(1, 0, 1, 0, 40'h80000000, 0, 0,       1, 1, 40'h80000000, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,                  0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 40'h500, 40'h504, 0,      0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 40'h100, 0,            1, 1, 40'h100, 0, 0);
    add(1, 0, 1, 1, 40'h104, 40'h108, 0,      3, 1, 40'h100, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,                  2, 1, 40'h104, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,                  1, 1, 40'h108, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,                  0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(1, 0, 1, 1, 40'h1000 + 40'(8*i), 40'h1004 + 40'(8*i), 0,
          5'(2*(i+1)), 1, 40'h1000, 0, 0);
    add(1, 0, 1, 0, 40'h1038, 0, 0,           15, 1, 40'h1000, 0, 0);
    add(1, 0, 1, 1, 40'h200, 40'h204, 0,      16, 1, 40'h1000, 1, 1);
    add(1, 0, 1, 1, 40'h208, 40'h20c, 0,      16, 1, 40'h1000, 1, 3);
    add(1, 0, 1, 1, 40'h210, 40'h214, 1,      15, 1, 40'h1004, 1, 5);
    for (int k = 1; k <= 8; k++)
      add(1, 0, 0, 0, 0, 0, 1, 5'(15-k), 1, 40'h1004 + 40'(4*k), 1, 5);
    add(1, 1, 1, 1, 40'h300, 40'h304, 1,      0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 40'h400, 0, 0,            1, 1, 40'h400, 0, 0);

    #12;
    reset = 1'b0;
    $display("reset: count=%0d valid=%0b ovf=%0b drops=%0d", count, out_valid, overflow, drop_count);
    chk("reset count", 64'(count), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset drop_count", 64'(drop_count), 64'd0);
    chk_head("reset", 1'b0, '0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.en, v.clr, v.v0, v.v1, v.a0, v.a1, v.rdy);
      $display("vec %0d: count=%0d valid=%0b head=%h ovf=%0b drops=%0d",
               i, count, out_valid, out_iaddr, overflow, drop_count);
      chk($sformatf("vec%0d count", i), 64'(count), 64'(v.exp_count));
      chk($sformatf("vec%0d overflow", i), 64'(overflow), 64'(v.exp_ovf));
      chk($sformatf("vec%0d drop_count", i), 64'(drop_count), 64'(v.exp_drop));
      chk_head($sformatf("vec%0d", i), v.exp_valid, v.exp_head);
    end

    // Wrap-around: dual-lane cycles interleaved with drain-only cycles, checked against a queue model
    mq.push_back(40'h400);
    for (int p = 0; p < 80; p++) begin
      logic        dual;
      logic [39:0] a0;
      dual   = (p % 2 == 0);
      a0     = 40'h2000 + 40'(8*(p/2));
      n_free = 16 - mq.size();
      if (mq.size() != 0) void'(mq.pop_front());
      n_req = dual ? 2 : 0;
      if (n_req > n_free) n_req = n_free;
      if (n_req >= 1) mq.push_back(a0);
      if (n_req == 2) mq.push_back(a0 + 40'h4);
      drive(1, 0, dual, dual, a0, a0 + 40'h4, 1);
      $display("wrap %0d: count=%0d head=%h drops=%0d", p, count, out_iaddr, drop_count);
      chk($sformatf("wrap%0d count", p), 64'(count), 64'(mq.size()));
      chk($sformatf("wrap%0d drop_count", p), 64'(drop_count), 64'd0);
      chk_head($sformatf("wrap%0d", p), mq.size() != 0, (mq.size() != 0) ? mq[0] : 40'h0);
    end

    // Asynchronous reset in the middle of a clock phase
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("pre-reset drain count", 64'(count), 64'd0);
    drive(1, 0, 1, 1, 40'h600, 40'h604, 0);
    $display("pre-reset: count=%0d head=%h", count, out_iaddr);
    chk("pre-reset count", 64'(count), 64'd2);
    chk_head("pre-reset", 1'b1, 40'h600);
    #2;
    reset = 1'b1;
    #1;
    $display("async reset: count=%0d valid=%0b head=%h", count, out_valid, out_iaddr);
    chk("async reset count", 64'(count), 64'd0);
    chk("async reset overflow", 64'(overflow), 64'd0);
    chk("async reset drop_count", 64'(drop_count), 64'd0);
    chk_head("async reset", 1'b0, '0);
    #2;
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 1);
    $display("post-reset idle: count=%0d valid=%0b", count, out_valid);
    chk("post-reset count", 64'(count), 64'd0);
    chk_head("post-reset", 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
